// File: rtl/matmul_stream_ctrl.sv
// Byte-stream controller for the 3x3 matrix multiplier: assembles A and B from an
// operand stream, triggers the multiplier, then drains the 9 result bytes.
module matmul_stream_ctrl #(
  parameter int DATA_W      = 8,
  parameter int RESULT_WAIT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_mm_a [9],
  output logic [DATA_W-1:0] o_mm_b [9],
  output logic              o_mm_trigger,
  input  logic              i_mm_ready,
  input  logic [DATA_W-1:0] i_mm_result [9],
  output logic              o_busy,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    FIRE      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    SETTLE    = 3'd4,
    DRAIN     = 3'd5
  } state_t;

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [3:0]        idx_q;
  logic [3:0]        settle_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              trigger_q;
  logic [DATA_W-1:0] a_q   [9];
  logic [DATA_W-1:0] b_q   [9];
  logic [DATA_W-1:0] buf_q [9];

  logic              in_xfer;
  logic              out_xfer;
  logic [3:0]        b_sel;

  // Both streams transfer on a clock edge where valid and ready are both high;
  // a producer holding valid must keep its data stable until that edge.
  assign in_xfer  = i_in_valid && in_ready_q;
  assign out_xfer = out_valid_q && i_out_ready;
  assign b_sel    = 4'(cnt_q - 5'd9);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      settle_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      trigger_q   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        buf_q[i] <= '0;
      end
    end else begin
      trigger_q <= 1'b0;
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            if (cnt_q < 5'd9) a_q[cnt_q[3:0]] <= i_in_data;
            else              b_q[b_sel]      <= i_in_data;
            if (cnt_q == 5'd17) begin
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= FIRE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        FIRE: begin
          if (i_mm_ready) begin
            trigger_q <= 1'b1;
            state_q   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // Ready is still high while the trigger pulse is out; wait for it to fall.
          if (!i_mm_ready) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_mm_ready) begin
            settle_q <= 4'(RESULT_WAIT);
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q == 4'd0) begin
            for (int i = 0; i < 9; i++) buf_q[i] <= i_mm_result[i];
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DRAIN;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (idx_q == 4'd8) begin
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= LOAD;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign o_in_ready   = in_ready_q;
  assign o_out_valid  = out_valid_q;
  assign o_out_data   = buf_q[idx_q];
  assign o_mm_trigger = trigger_q;
  assign o_mm_a       = a_q;
  assign o_mm_b       = b_q;
  assign o_busy       = !((state_q == LOAD) && (cnt_q == 5'd0));
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Bench for matmul_stream_ctrl: behavioural multiplier model, operand driver,
// and an output scoreboard fed from the driven matrices.
module tb_matmul_stream_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] mm_a   [9];
  logic [W-1:0] mm_b   [9];
  logic [W-1:0] mm_res [9];
  logic         mm_trig;
  logic         mm_ready;
  logic         busy;
  logic [2:0]   dbg_state;

  logic         mm_rdy_q;
  logic         mm_hold;
  int           errors   = 0;
  int           checks   = 0;
  int           cyc      = 0;
  int           trig_cnt = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] ma [9];
  logic [W-1:0] mb [9];

  matmul_stream_ctrl #(.DATA_W(W), .RESULT_WAIT(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_mm_a       (mm_a),
    .o_mm_b       (mm_b),
    .o_mm_trigger (mm_trig),
    .i_mm_ready   (mm_ready),
    .i_mm_result  (mm_res),
    .o_busy       (busy),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- multiplier model: busy for one cycle after a trigger ----------------
  assign mm_ready = mm_rdy_q && !mm_hold;

  always @(posedge clk) begin : mm_model
    int acc;
    if (rst) begin
      mm_rdy_q <= 1'b1;
      for (int i = 0; i < 9; i++) mm_res[i] <= '0;
    end else if (mm_trig) begin
      mm_rdy_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          acc = 0;
          for (int k = 0; k < 3; k++) acc = acc + int'(mm_a[r*3+k]) * int'(mm_b[k*3+c]);
          mm_res[r*3+c] <= W'(acc);
        end
      end
    end else begin
      mm_rdy_q <= 1'b1;
    end
  end

  always @(negedge clk) if (mm_trig) trig_cnt++;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : sb
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got byte %0d, required no output", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_byte: got %0d, required %0d", out_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected();
    int acc;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        acc = 0;
        for (int k = 0; k < 3; k++) acc = acc + int'(ma[r*3+k]) * int'(mb[k*3+c]);
        exp_q.push_back(W'(acc));
      end
    end
  endtask

  task automatic send_byte(input logic [W-1:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: o_in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_matrices(input bit toggle);
    push_expected();
    for (int i = 0; i < 18; i++) begin
      send_byte(i < 9 ? ma[i] : mb[i-9]);
      if (toggle && i != 17) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; mm_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++; if (mm_trig !== 1'b0) begin errors++; $display("FAIL rst_trigger: got %b, required 0", mm_trig); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", dbg_state); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (mm_a[i] !== '0 || mm_b[i] !== '0) begin
        errors++;
        $display("FAIL rst_mm_ab[%0d]: got a=%0d b=%0d, required 0", i, mm_a[i], mm_b[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_identity();
    int t0, n;
    for (int i = 0; i < 9; i++) begin
      ma[i] = (i % 4 == 0) ? W'(1) : W'(0);
      mb[i] = W'(i + 1);
    end
    trig_cnt = 0;
    load_matrices(1'b0);
    t0 = cyc;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (cyc - t0 != 7) begin errors++; $display("FAIL id_latency: got %0d cycles, required 7", cyc - t0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL id_busy_drain: got %b, required 1", busy); end
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL id_drain: %0d bytes left, required 0", exp_q.size()); end
    checks++; if (trig_cnt != 1) begin errors++; $display("FAIL id_trigger_pulses: got %0d, required 1", trig_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL id_valid_drop: got %b, required 0", out_valid); end
  endtask

  task automatic test_all_twos();
    int n;
    for (int i = 0; i < 9; i++) begin ma[i] = W'(2); mb[i] = W'(3); end
    load_matrices(1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL twos_drain: %0d bytes left, required 0", exp_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL twos_busy_end: got %b, required 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL twos_in_ready_end: got %b, required 1", in_ready); end
  endtask

  task automatic test_wrap();
    int n;
    for (int i = 0; i < 9; i++) begin ma[i] = W'(16); mb[i] = W'(16); end
    load_matrices(1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d bytes left, required 0", exp_q.size()); end
  endtask

  task automatic test_stall_toggle();
    int n;
    for (int i = 0; i < 9; i++) begin
      ma[i] = (i % 4 == 0) ? W'(1) : W'(0);
      mb[i] = W'(i + 1);
    end
    out_ready = 1'b1;
    load_matrices(1'b1);
    n = 0;
    while (exp_q.size() > 5 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(5)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%0d, required valid=1 data=5", k, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d bytes left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_abort();
    int n;
    for (int i = 0; i < 9; i++) begin
      ma[i] = (i % 4 == 0) ? W'(1) : W'(0);
      mb[i] = W'(9 - i);
    end
    for (int i = 0; i < 11; i++) send_byte(i < 9 ? ma[i] : mb[i-9]);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b, required 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b, required 0", in_ready); end
    checks++; if (mm_a[0] !== '0) begin errors++; $display("FAIL abort_mm_a0: got %0d, required 0", mm_a[0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    load_matrices(1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_drain: %0d bytes left, required 0", exp_q.size()); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_extra_out: got valid %b, required 0", out_valid); end
  endtask

  task automatic test_mm_ready_low();
    int n;
    for (int i = 0; i < 9; i++) begin
      ma[i] = W'($urandom_range(0, 255));
      mb[i] = W'($urandom_range(0, 255));
    end
    trig_cnt = 0;
    mm_hold = 1'b1;
    load_matrices(1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (trig_cnt != 0 || dbg_state !== 3'd1) begin
        errors++;
        $display("FAIL fire_hold[%0d]: got pulses=%0d state=%0d, required pulses=0 state=1", k, trig_cnt, dbg_state);
      end
    end
    mm_hold = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fire_drain: %0d bytes left, required 0", exp_q.size()); end
    checks++; if (trig_cnt != 1) begin errors++; $display("FAIL fire_pulses: got %0d, required 1", trig_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 9; i++) begin
        ma[i] = W'($urandom_range(0, 255));
        mb[i] = W'($urandom_range(0, 255));
      end
      load_matrices(1'b0);
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      out_ready = 1'b1;
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain[%0d]: %0d bytes left, required 0", t, exp_q.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_twos();
    test_wrap();
    test_stall_toggle();
    test_reset_abort();
    test_mm_ready_low();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_stream_ctrl.md
Name: matmul_stream_ctrl

Overview:
Byte-stream front/back end for the 3x3 8-bit matrix multiplier.
- Accepts 18 operand bytes on a valid/ready input stream and assembles them into matrices A and B.
- Pulses the multiplier trigger, waits for completion, captures the 9 result bytes, and streams them out on a valid/ready output stream.
- Sits between the byte transport (UART/SPI deserialiser) and the matmul block. Drives its i_a/i_b/i_trigger and consumes its o_ready/o_result.

Parameters:
DATA_W, 8, element width; must match the multiplier.
RESULT_WAIT, 2, cycles to wait after multiplier ready re-asserts before sampling i_mm_result; legal range 1..15.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_in_data  in  DATA_W  operand byte.
i_in_valid  in  1  operand byte valid.
o_in_ready  out  1  controller accepts operand byte this cycle.
o_out_data  out  DATA_W  result byte.
o_out_valid  out  1  result byte valid.
i_out_ready  in  1  sink accepts result byte.
o_mm_a  out  DATA_W x 9 (unpacked [9])  matrix A to multiplier, row-major [row*3+col].
o_mm_b  out  DATA_W x 9 (unpacked [9])  matrix B to multiplier, row-major.
o_mm_trigger  out  1  one-cycle start pulse to multiplier.
i_mm_ready  in  1  multiplier ready flag.
i_mm_result  in  DATA_W x 9 (unpacked [9])  multiplier result, row-major.
o_busy  out  1  high in every state except LOAD with zero bytes received.

Behaviour:
- Reset (i_rst high at clock edge), regardless of state:
  - state=LOAD, byte counter=0, result index=0.
  - o_in_ready=0 in the reset cycle, then 1 from the first cycle after reset.
  - o_out_valid=0, o_mm_trigger=0, o_busy=0.
  - o_mm_a, o_mm_b, and the result buffer all cleared to 0.
  - Reset mid-operation abandons any partial load, pending multiply or partial drain. No result bytes are emitted afterwards.
- Input handshake: a transfer occurs when i_in_valid && o_in_ready at a clock edge. o_in_ready is registered and is 1 only in LOAD.
- Output handshake: a transfer occurs when o_out_valid && i_out_ready. Once o_out_valid is high, o_out_data must hold stable until accepted.
- States:
  - LOAD:
    - Each accepted byte is written in order: bytes 0..8 to o_mm_a[0..8], bytes 9..17 to o_mm_b[0..8]; the counter increments.
    - On acceptance of byte 17: counter clears to 0, o_in_ready drops on the next cycle, and the state goes to FIRE.
    - i_in_valid low leaves the counter unchanged; there is no timeout.
  - FIRE:
    - If i_mm_ready=1: assert o_mm_trigger for exactly one cycle (registered, so it is high in the cycle after FIRE is entered) and go to WAIT_BUSY.
    - If i_mm_ready=0: stay in FIRE and do not trigger.
  - WAIT_BUSY: wait until i_mm_ready=0 is observed, then go to WAIT_DONE. The multiplier drops ready in the cycle after the trigger.
  - WAIT_DONE: wait until i_mm_ready=1, then load the settle counter with RESULT_WAIT and go to SETTLE.
  - SETTLE:
    - Decrement the counter each cycle.
    - When it reaches 0: latch all 9 i_mm_result elements into the internal buffer in one cycle, and go to DRAIN with index 0.
  - DRAIN:
    - o_out_valid=1 with o_out_data=buffer[index].
    - On each output transfer the index increments.
    - On the transfer of index 8: o_out_valid drops on the next cycle, and the state goes to LOAD with o_in_ready=1.
    - i_out_ready low holds the current byte indefinitely.
- o_mm_a and o_mm_b hold their values from the end of LOAD until overwritten by the next load. The multiplier samples them on the trigger edge.
- No arithmetic is performed here. Results are the multiplier's, modulo 2^DATA_W.
- Input and output never overlap. A new load cannot start until all 9 result bytes have drained.
- Minimum latency, counted from the acceptance of byte 17 to the first o_out_valid, with i_mm_ready idle-high: FIRE 1 + trigger 1 + WAIT_BUSY 1 + WAIT_DONE 1 + RESULT_WAIT + 1 capture = RESULT_WAIT+5 cycles, i.e. 7 at default.

Test Plan:
- A=identity (1,0,0,0,1,0,0,0,1), B=1..9, sink always ready -> out bytes 1,2,3,4,5,6,7,8,9; o_mm_trigger high exactly 1 cycle; first o_out_valid 7 cycles after byte 17 accepted.
- A all 2, B all 3 -> 9 bytes of 18 (0x12); o_busy low after final transfer; o_in_ready=1 the next cycle.
- A all 16, B all 16 -> 9 bytes of 0x00 (3*256 wraps to 0).
- i_in_valid toggled 1-0-1 every other cycle, and i_out_ready low for 5 cycles at index 4 -> no lost or duplicated bytes; o_out_data for A=identity, B=1..9 stays 5 while stalled; sequence still 1..9.
- i_rst asserted after 11 input bytes, then a full new 18-byte load (A=identity, B=9..1) -> no output from the aborted load; output 9,8,7,6,5,4,3,2,1.
- i_mm_ready forced low during FIRE for 3 cycles -> no trigger pulse until it returns high, then exactly one pulse.
